// File: rtl/rou_load_pkg.sv
// Shared types, sizing and mapping helpers for the ROU table write sequencer.
// Optional feature macro ROU_LOAD_CHECKSUM_EN is consumed by rou_load_ctrl.
package rou_load_pkg;

  localparam int BIT_WIDTH = 32;
  localparam int LINE_SIZE = 4;
  localparam int MAX_LEN   = 16;

  localparam int STAGE_MAX = $clog2(MAX_LEN);
  localparam int STG_W     = $clog2(STAGE_MAX);
  localparam int ADDR_W    = $clog2(MAX_LEN);
  localparam int HALF_W    = BIT_WIDTH / 2;
  localparam int LINE_LOG2 = $clog2(LINE_SIZE);
  localparam int WE_W      = 2 * LINE_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FIN
  } state_t;

  // Early stages hold fewer entries than a line, so they spread across columns.
  function automatic int col_log2(input int stage);
    return (LINE_LOG2 > stage) ? (LINE_LOG2 - stage) : 0;
  endfunction

  function automatic int words_total(input int log_n);
    return 2 * ((1 << log_n) - 1);
  endfunction

endpackage

// File: rtl/rou_addr_gen.sv
// Combinational map from (stage, entry, half) to buffer row address and
// one-hot half-column write enable.
module rou_addr_gen
  import rou_load_pkg::*;
(
  input  logic [STG_W-1:0]  stage,
  input  logic [ADDR_W-1:0] entry,
  input  logic              half,
  output logic [ADDR_W-1:0] addr,
  output logic [WE_W-1:0]   we
);

  int cl;
  int col;

  // NOTE: every variable is assigned on every pass, so no latch is inferred.
  always_comb begin
    cl   = col_log2(int'(stage));
    col  = int'(entry) & ((1 << cl) - 1);
    addr = entry >> cl;
    we   = WE_W'(1) << (2 * col + int'(half));
  end

endmodule

// File: rtl/rou_load_ctrl.sv
// Write-side sequencer for per-stage twiddle tables: walks stage/entry/half
// counters over a host word stream. Optional checksum port: ROU_LOAD_CHECKSUM_EN.
module rou_load_ctrl
  import rou_load_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [STG_W:0]    log_n,
  input  logic              in_valid,
  input  logic [HALF_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_valid,
  output logic [STG_W-1:0]  wr_stage,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WE_W-1:0]   wr_we,
  output logic [HALF_W-1:0] wr_din,
  output logic              busy,
  output logic              done
`ifdef ROU_LOAD_CHECKSUM_EN
  ,
  output logic [HALF_W-1:0] checksum
`endif
);

  state_t            state, state_nx;
  logic [STG_W:0]    log_n_q;
  logic [STG_W-1:0]  s_q;
  logic [ADDR_W-1:0] k_q;
  logic              h_q;
  logic              start_ok, accept, last_word;
  logic [ADDR_W-1:0] k_last, map_addr;
  logic [WE_W-1:0]   map_we;

  assign start_ok  = start && (log_n != '0) && (int'(log_n) <= STAGE_MAX);
  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign k_last    = ADDR_W'((1 << s_q) - 1);
  assign last_word = h_q && (k_q == k_last) && ({1'b0, s_q} == log_n_q - (STG_W + 1)'(1));

  rou_addr_gen u_addr_gen (
    .stage (s_q),
    .entry (k_q),
    .half  (h_q),
    .addr  (map_addr),
    .we    (map_we)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_ok) state_nx = LOAD;
      LOAD:    if (accept && last_word) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Half toggles every word; entry and stage roll over after the high half.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      log_n_q <= '0;
      s_q     <= '0;
      k_q     <= '0;
      h_q     <= 1'b0;
    end else if ((state == IDLE) && start_ok) begin
      log_n_q <= log_n;
      s_q     <= '0;
      k_q     <= '0;
      h_q     <= 1'b0;
    end else if (accept) begin
      h_q <= ~h_q;
      if (h_q) begin
        if (k_q == k_last) begin
          k_q <= '0;
          s_q <= s_q + STG_W'(1);
        end else begin
          k_q <= k_q + ADDR_W'(1);
        end
      end
    end
  end

  // done rises as FIN retires, one cycle after the final write strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_valid <= 1'b0;
      wr_stage <= '0;
      wr_addr  <= '0;
      wr_we    <= '0;
      wr_din   <= '0;
      done     <= 1'b0;
    end else begin
      wr_valid <= accept;
      wr_we    <= accept ? map_we : '0;
      if (accept) begin
        wr_stage <= s_q;
        wr_addr  <= map_addr;
        wr_din   <= in_data;
      end
      done <= (state == FIN);
    end
  end

`ifdef ROU_LOAD_CHECKSUM_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           checksum <= '0;
    else if ((state == IDLE) && start_ok) checksum <= '0;
    else if (accept)                     checksum <= checksum ^ in_data;
  end
`endif

endmodule
